// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: data width and controller states.
package div_pkg;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOADN,
    LOADP,
    LOOP,
    DONE
  } state_e;
endpackage

// File: rtl/div_by_sub_if.sv
// Request/result bundle of the divider: Start and Data_in in; Stop and the N/P/Q registers out.
interface div_by_sub_if;
  import div_pkg::*;

  logic              Start;
  logic [DATA_W-1:0] Data_in;
  logic              Stop;
  logic [DATA_W-1:0] Nw;
  logic [DATA_W-1:0] Pw;
  logic [DATA_W-1:0] Qw;

  modport master (output Start, output Data_in, input Stop, input Nw, input Pw, input Qw);
  modport slave  (input Start, input Data_in, output Stop, output Nw, output Pw, output Qw);
endinterface

// File: rtl/div_ctrlpath.sv
// Divider controller: sequences clear, operand loads and the subtract loop.
module div_ctrlpath
  import div_pkg::*;
(
  input  logic Clk,
  input  logic Rst_n,
  input  logic Start,
  input  logic PgtN,
  input  logic PeqZ,
  output logic LoadN,
  output logic LoadP,
  output logic LoadS,
  output logic Clear,
  output logic IncQ,
  output logic Stop
);

  state_e state_q;
  logic   clear_q;
  logic   loadn_q;
  logic   loadp_q;
  logic   loop_end;

  assign loop_end = PgtN | PeqZ;

  // Setup strobes are registered on entry to their state; the loop strobes
  // depend on the live comparison and so stay combinational.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      clear_q <= 1'b0;
      loadn_q <= 1'b0;
      loadp_q <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      loadn_q <= 1'b0;
      loadp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_q <= CLEAR;
            clear_q <= 1'b1;
          end
        end
        CLEAR: begin
          state_q <= LOADN;
          loadn_q <= 1'b1;
        end
        LOADN: begin
          state_q <= LOADP;
          loadp_q <= 1'b1;
        end
        LOADP: state_q <= LOOP;
        LOOP: begin
          if (loop_end) state_q <= DONE;
        end
        DONE: begin
          if (!Start) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Clear = clear_q;
  assign LoadN = loadn_q;
  assign LoadP = loadp_q;
  assign LoadS = (state_q == LOOP) && !loop_end;
  assign IncQ  = (state_q == LOOP) && !loop_end;
  assign Stop  = (state_q == DONE) || ((state_q == LOOP) && loop_end);

endmodule

// File: rtl/div_datapath.sv
// Divider datapath: N/P/Q registers with subtractor, quotient incrementer and comparator.
module div_datapath
  import div_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              LoadN,
  input  logic              LoadP,
  input  logic              LoadS,
  input  logic              Clear,
  input  logic              IncQ,
  output logic              PgtN,
  output logic              PeqZ,
  output logic [DATA_W-1:0] Nw,
  output logic [DATA_W-1:0] Pw,
  output logic [DATA_W-1:0] Qw
);

  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] p_q, p_d;
  logic [DATA_W-1:0] q_q, q_d;

  // LoadS only fires when P <= N, so the subtract cannot wrap.
  always_comb begin
    n_d = n_q;
    p_d = p_q;
    q_d = q_q;
    if (Clear) q_d = '0;
    if (LoadN) n_d = Data_in;
    if (LoadP) p_d = Data_in;
    if (LoadS) n_d = n_q - p_q;
    if (IncQ)  q_d = q_q + DATA_W'(1);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      n_q <= '0;
      p_q <= '0;
      q_q <= '0;
    end else begin
      n_q <= n_d;
      p_q <= p_d;
      q_q <= q_d;
    end
  end

  assign PgtN = (p_q > n_q);
  assign PeqZ = (p_q == '0);
  assign Nw   = n_q;
  assign Pw   = p_q;
  assign Qw   = q_q;

endmodule

// File: rtl/div_by_sub.sv
// Unsigned 8-bit repeated-subtraction divider: controller plus datapath, wiring only.
module div_by_sub (
  input  logic         Clk,
  input  logic         Rst_n,
  div_by_sub_if.slave  bus
);

  logic LoadN, LoadP, LoadS, Clear, IncQ;
  logic PgtN, PeqZ;

  div_ctrlpath u_ctrl (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (bus.Start),
    .PgtN  (PgtN),
    .PeqZ  (PeqZ),
    .LoadN (LoadN),
    .LoadP (LoadP),
    .LoadS (LoadS),
    .Clear (Clear),
    .IncQ  (IncQ),
    .Stop  (bus.Stop)
  );

  div_datapath u_dp (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Data_in (bus.Data_in),
    .LoadN   (LoadN),
    .LoadP   (LoadP),
    .LoadS   (LoadS),
    .Clear   (Clear),
    .IncQ    (IncQ),
    .PgtN    (PgtN),
    .PeqZ    (PeqZ),
    .Nw      (bus.Nw),
    .Pw      (bus.Pw),
    .Qw      (bus.Qw)
  );

endmodule

// File: tb/tb_div_by_sub.sv
// Directed bench for div_by_sub: hand-computed quotients, remainders and Stop timing.
module tb_div_by_sub;

  logic Clk;
  logic Rst_n;
  int   checks;
  int   errors;

  div_by_sub_if bus ();

  div_by_sub dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered one time unit after a rising edge with the controller in IDLE;
  // returns at the same phase, back in IDLE with Start low.
  task automatic run_div(input string tag, input logic [7:0] n, input logic [7:0] p,
                         input int q, input logic [7:0] r);
    bus.Start   = 1'b1;
    bus.Data_in = n;
    @(posedge Clk); #1;                         // e0
    check({tag, "_start_nostop"}, {31'd0, bus.Stop}, 32'd0);
    @(posedge Clk); #1;                         // e1
    check({tag, "_q_clear"}, {24'd0, bus.Qw}, 32'd0);
    @(posedge Clk); #1;                         // e2
    check({tag, "_n_load"}, {24'd0, bus.Nw}, {24'd0, n});
    bus.Data_in = p;
    @(posedge Clk); #1;                         // e3
    check({tag, "_p_load"}, {24'd0, bus.Pw}, {24'd0, p});
    bus.Data_in = 8'hA5;
    for (int k = 0; k <= q; k++) begin
      check({tag, "_stop_timing"}, {31'd0, bus.Stop}, (k == q) ? 32'd1 : 32'd0);
      if (k < q) begin
        @(posedge Clk); #1;
      end
    end
    check({tag, "_quot"}, {24'd0, bus.Qw}, q);
    check({tag, "_rem"},  {24'd0, bus.Nw}, {24'd0, r});
    repeat (3) begin
      @(posedge Clk); #1;
    end
    check({tag, "_hold_stop"}, {31'd0, bus.Stop}, 32'd1);
    check({tag, "_hold_quot"}, {24'd0, bus.Qw}, q);
    check({tag, "_hold_rem"},  {24'd0, bus.Nw}, {24'd0, r});
    bus.Start = 1'b0;
    @(posedge Clk); #1;
    check({tag, "_idle_stop"}, {31'd0, bus.Stop}, 32'd0);
    @(posedge Clk); #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    Rst_n       = 1'b0;
    bus.Start   = 1'b0;
    bus.Data_in = 8'd0;

    #1;
    check("rst_stop", {31'd0, bus.Stop}, 32'd0);
    check("rst_n",    {24'd0, bus.Nw},   32'd0);
    check("rst_p",    {24'd0, bus.Pw},   32'd0);
    check("rst_q",    {24'd0, bus.Qw},   32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    check("idle_stop", {31'd0, bus.Stop}, 32'd0);

    run_div("d53_23",   8'd53,  8'd23,  2,   8'd7);
    run_div("d16_3",    8'd16,  8'd3,   5,   8'd1);
    run_div("d250_15",  8'd250, 8'd15,  16,  8'd10);
    run_div("d59_11",   8'd59,  8'd11,  5,   8'd4);
    run_div("d234_234", 8'd234, 8'd234, 1,   8'd0);
    run_div("d21_31",   8'd21,  8'd31,  0,   8'd21);
    run_div("d15_250",  8'd15,  8'd250, 0,   8'd15);
    run_div("d0_14",    8'd0,   8'd14,  0,   8'd0);
    run_div("d9_0",     8'd9,   8'd0,   0,   8'd9);
    run_div("d255_1",   8'd255, 8'd1,   255, 8'd0);

    // Abort mid-loop: 250/15 after four subtractions, then asynchronous reset.
    bus.Start   = 1'b1;
    bus.Data_in = 8'd250;
    repeat (3) @(posedge Clk);
    #1 bus.Data_in = 8'd15;
    @(posedge Clk);
    repeat (4) @(posedge Clk);
    #1;
    check("abort_pre_q", {24'd0, bus.Qw}, 32'd4);
    check("abort_pre_n", {24'd0, bus.Nw}, 32'd190);
    check("abort_pre_stop", {31'd0, bus.Stop}, 32'd0);
    #2 Rst_n = 1'b0;
    #1;
    check("abort_stop", {31'd0, bus.Stop}, 32'd0);
    check("abort_n",    {24'd0, bus.Nw},   32'd0);
    check("abort_p",    {24'd0, bus.Pw},   32'd0);
    check("abort_q",    {24'd0, bus.Qw},   32'd0);
    bus.Start = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    check("abort_idle_stop", {31'd0, bus.Stop}, 32'd0);
    check("abort_idle_q",    {24'd0, bus.Qw},   32'd0);

    run_div("d100_7", 8'd100, 8'd7, 14, 8'd2);
    run_div("d100_7_again", 8'd100, 8'd7, 14, 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
